// File: rtl/subsurf_pkg.sv
// Shared types for the multi-level subdivision sequencer: RAM mux owner codes,
// FSM states and the default RAM address width.
package subsurf_pkg;

    localparam int DEF_ADDR_WIDTH = 11;

    typedef enum logic [2:0] {
        SEL_NONE     = 3'd0,
        SEL_SUBDIV   = 3'd1,
        SEL_NEIGHBOR = 3'd2,
        SEL_AVERAGER = 3'd3,
        SEL_COPY     = 3'd4
    } sel_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_COPY,
        ST_FIN
    } state_e;

    // Stage owner code to its bit in stage_start/stage_busy.
    function automatic logic [2:0] stage_onehot(input sel_e s);
        case (s)
            SEL_SUBDIV:   return 3'b001;
            SEL_NEIGHBOR: return 3'b010;
            SEL_AVERAGER: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/subsurf_sched_copier.sv
// Bank 2 -> bank 0 copy engine: one read per cycle, each write trails its read by one
// cycle so the synchronous bank 2 read data can be forwarded straight into bank 0.
module bank_copier #(
    parameter int ADDR_WIDTH = subsurf_pkg::DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  done,
    output logic                  cp_en0,
    output logic [3:0]            cp_we0,
    output logic [ADDR_WIDTH-1:0] cp_a0,
    output logic [31:0]           cp_di0,
    output logic                  cp_en2,
    output logic [ADDR_WIDTH-1:0] cp_a2,
    input  logic [31:0]           do2
);

    logic                active;
    logic [ADDR_WIDTH:0] k;
    logic [ADDR_WIDTH:0] k_inc;

    assign k_inc  = k + 1'b1;
    assign done   = active && (k == len);
    assign cp_di0 = do2;

    // k is the copy cycle index; the final cycle (k == len) only writes the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active <= 1'b0;
            k      <= '0;
            cp_en2 <= 1'b0;
            cp_a2  <= '0;
            cp_en0 <= 1'b0;
            cp_we0 <= 4'h0;
            cp_a0  <= '0;
        end else if (abort || (active && done)) begin
            active <= 1'b0;
            k      <= '0;
            cp_en2 <= 1'b0;
            cp_a2  <= '0;
            cp_en0 <= 1'b0;
            cp_we0 <= 4'h0;
            cp_a0  <= '0;
        end else if (go) begin
            active <= 1'b1;
            k      <= '0;
            cp_en2 <= (len != '0);
            cp_a2  <= '0;
            cp_en0 <= 1'b0;
            cp_we0 <= 4'h0;
            cp_a0  <= '0;
        end else if (active) begin
            k      <= k_inc;
            cp_en2 <= (k_inc < len);
            cp_a2  <= (k_inc < len) ? k_inc[ADDR_WIDTH-1:0] : '0;
            cp_en0 <= 1'b1;
            cp_we0 <= 4'hF;
            cp_a0  <= k[ADDR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/subsurf_sched.sv
// Multi-level sequencer: runs subdiv -> neighbor -> averager per pass, copies the
// result bank back to the object bank between passes, and owns the RAM mux select.
module subsurf_sched
    import subsurf_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int START_HOLD = 3,
    parameter int WDOG_W     = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2:0]            levels,
    input  logic [ADDR_WIDTH:0]   copy_len,
    input  logic [2:0]            stage_busy,
    output logic [2:0]            stage_start,
    output sel_e                  sel,
    output logic                  cp_en0,
    output logic [3:0]            cp_we0,
    output logic [ADDR_WIDTH-1:0] cp_a0,
    output logic [31:0]           cp_di0,
    output logic                  cp_en2,
    output logic [ADDR_WIDTH-1:0] cp_a2,
    input  logic [31:0]           do2,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            level_idx
);

    localparam int HOLD_W = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};

    state_e              state, state_n;
    sel_e                stage_q, stage_n, sel_n;
    logic [2:0]          levels_q, levels_n, level_n, start_n;
    logic [ADDR_WIDTH:0] len_q, len_n;
    logic                busy_n, err_n, done_n, cur_busy;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [WDOG_W-1:0]   wdog;
    logic                copy_go, copy_done;

    always_comb begin
        state_n  = state;
        stage_n  = stage_q;
        level_n  = level_idx;
        levels_n = levels_q;
        len_n    = len_q;
        busy_n   = busy;
        err_n    = err;
        done_n   = 1'b0;
        cur_busy = |(stage_busy & stage_onehot(stage_q));

        case (state)
            ST_IDLE: begin
                if (start) begin
                    err_n = 1'b0;
                    if (levels != 3'd0) begin
                        levels_n = levels;
                        len_n    = copy_len;
                        stage_n  = SEL_SUBDIV;
                        level_n  = 3'd0;
                        busy_n   = 1'b1;
                        state_n  = ST_LAUNCH;
                    end else begin
                        state_n = ST_FIN;
                    end
                end
            end
            ST_LAUNCH: begin
                if (hold_cnt == HOLD_LAST) state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (wdog == WDOG_LAST) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else if (!cur_busy) begin
                    case (stage_q)
                        SEL_SUBDIV: begin
                            stage_n = SEL_NEIGHBOR;
                            state_n = ST_LAUNCH;
                        end
                        SEL_NEIGHBOR: begin
                            stage_n = SEL_AVERAGER;
                            state_n = ST_LAUNCH;
                        end
                        default: begin
                            if (level_idx == levels_q - 3'd1) begin
                                done_n  = 1'b1;
                                state_n = ST_FIN;
                            end else if (len_q == '0) begin
                                level_n = level_idx + 3'd1;
                                stage_n = SEL_SUBDIV;
                                state_n = ST_LAUNCH;
                            end else begin
                                state_n = ST_COPY;
                            end
                        end
                    endcase
                end
            end
            ST_COPY: begin
                if (copy_done) begin
                    level_n = level_idx + 3'd1;
                    stage_n = SEL_SUBDIV;
                    state_n = ST_LAUNCH;
                end
            end
            ST_FIN: begin
                // A zero-level job enters with done low, so FIN lingers one extra cycle to pulse it.
                if (done) begin
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    done_n = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (abort && (state != ST_IDLE)) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end

        case (state_n)
            ST_LAUNCH, ST_WAIT: sel_n = stage_n;
            ST_COPY:            sel_n = SEL_COPY;
            default:            sel_n = SEL_NONE;
        endcase
        start_n = (state_n == ST_LAUNCH) ? stage_onehot(stage_n) : 3'b000;
    end

    assign copy_go = (state == ST_WAIT) && (state_n == ST_COPY);

    // Outputs are registered from their next-state values so they change with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            stage_q     <= SEL_NONE;
            levels_q    <= 3'd0;
            len_q       <= '0;
            level_idx   <= 3'd0;
            busy        <= 1'b0;
            err         <= 1'b0;
            done        <= 1'b0;
            stage_start <= 3'b000;
            sel         <= SEL_NONE;
            hold_cnt    <= '0;
            wdog        <= '0;
        end else begin
            state       <= state_n;
            stage_q     <= stage_n;
            levels_q    <= levels_n;
            len_q       <= len_n;
            level_idx   <= level_n;
            busy        <= busy_n;
            err         <= err_n;
            done        <= done_n;
            stage_start <= start_n;
            sel         <= sel_n;
            hold_cnt    <= (state_n != state) ? '0 :
                           (state == ST_LAUNCH) ? hold_cnt + 1'b1 : hold_cnt;
            wdog        <= (state_n != state) ? '0 :
                           (state == ST_WAIT) ? wdog + 1'b1 : wdog;
        end
    end

    bank_copier #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_copier (
        .clk    (clk),
        .rst    (rst),
        .go     (copy_go),
        .abort  (abort),
        .len    (len_q),
        .done   (copy_done),
        .cp_en0 (cp_en0),
        .cp_we0 (cp_we0),
        .cp_a0  (cp_a0),
        .cp_di0 (cp_di0),
        .cp_en2 (cp_en2),
        .cp_a2  (cp_a2),
        .do2    (do2)
    );

endmodule

// File: doc/subsurf_sched.md
# subsurf_sched

Multi-level sequencer for the subdivision datapath. It runs `levels` passes of subdiv → neighbor → averager and drives each stage's start pulse. It watches each stage's busy flag and tells the top-level RAM mux which stage owns the banks. Between passes it copies the result bank (bank 2) back into the object bank (bank 0) so that the next pass reads the refined mesh. It replaces the single-pass in-line sequencing in the top level.

## Interface
Parameters:
- `ADDR_WIDTH`, 11: RAM word-address width.
- `START_HOLD`, 3: cycles each stage start is held high.
- `WDOG_W`, 20: watchdog counter width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a job; sampled only in IDLE.
- `abort` in 1: synchronous cancel, honoured in any non-IDLE state.
- `levels` in 3: number of subdivision passes, 0–7.
- `copy_len` in ADDR_WIDTH+1: words to copy from bank 2 to bank 0 between passes, 0–2048.
- `stage_busy` in 3: busy flags, [0] subdiv, [1] neighbor, [2] averager.
- `stage_start` out 3: start pulses, same bit order as `stage_busy`.
- `sel` out 3: RAM mux owner, a `subsurf_pkg::sel_e` value.
- `cp_en0`, `cp_we0[3:0]`, `cp_a0`, `cp_di0[31:0]` out: copy-engine write port on bank 0.
- `cp_en2`, `cp_a2` out: copy-engine read port on bank 2.
- `do2` in 32: bank 2 read data, one-cycle synchronous read.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `err` out 1: watchdog error; sticky until the next accepted `start`.
- `level_idx` out 3: current pass, 0-based.

## Operation
- States: IDLE, LAUNCH, WAIT, COPY, FIN.
- IDLE:
  - `start`=1 and `levels`≠0: latch `levels` and `copy_len`; stage ← SUBDIV; `level_idx` ← 0; `busy` ← 1; clear `err`; go to LAUNCH.
  - `start`=1 and `levels`=0: clear `err`, go to FIN. No stage is launched.
- LAUNCH: drive `stage_start[stage]`=1 for exactly START_HOLD cycles, then go to WAIT. `sel` = the stage for the whole of LAUNCH and WAIT.
- WAIT: when `stage_busy[stage]`=0:
  - after subdiv → LAUNCH neighbor.
  - after neighbor → LAUNCH averager.
  - after averager:
    - last pass (`level_idx` = levels−1) → FIN.
    - `copy_len`=0 → increment `level_idx`, go to LAUNCH subdiv.
    - otherwise → COPY.
- COPY: `sel`=SEL_COPY.
  - Each cycle k < `copy_len`: `cp_en2`=1, `cp_a2`=k.
  - Each cycle k ≥ 1: `cp_en0`=1, `cp_we0`=4'hF, `cp_a0`=k−1, `cp_di0`=`do2`.
  - Lasts `copy_len`+1 cycles. Then increment `level_idx` and go to LAUNCH subdiv.
- FIN: pulse `done` for 1 cycle, drop `busy`, return to IDLE.
- Watchdog: counter cleared on every state entry and counts in WAIT only. On reaching 2^WDOG_W−1 in WAIT:
  - set `err`;
  - drop all starts, `busy`=0, `sel`=SEL_NONE;
  - go to IDLE with no `done` pulse.
- `abort`: next state IDLE; all outputs except `err` and `level_idx` take their reset values; no `done` pulse. `abort` has priority over the watchdog and over normal transitions.
- `start` is ignored while `busy`=1.
- `levels` and `copy_len` changing mid-job have no effect; the latched copies are used.

## Timing
- Reset values: all outputs 0, `sel`=SEL_NONE, state IDLE.
- Every output is registered.
- `start` sampled at edge T:
  - `busy`=1 and `stage_start[0]`=1 from T+1;
  - `stage_start[0]` stays high through T+START_HOLD.
- WAIT first checks busy on the cycle after the last start-high cycle. Stages must raise busy within START_HOLD cycles of start.
- Busy low seen at edge W:
  - next stage start (or copy) begins at W+1;
  - otherwise FIN, with `done` at W+1 and `busy` low at W+2.
- Copy throughput: 1 word/cycle. Read-to-write latency: 1 cycle.
- `levels`=0: `done` at T+2, `busy` never rises.
- `rst` mid-job: immediate return to the reset values above; in-flight copy writes are dropped.

## Structure
- `subsurf_pkg` holds:
  - `sel_e` {SEL_NONE=0, SEL_SUBDIV=1, SEL_NEIGHBOR=2, SEL_AVERAGER=3, SEL_COPY=4};
  - the `state_e` enum;
  - `ADDR_WIDTH` default.
- Sub-module `bank_copier` takes `go` and `len` and returns `done`; it owns the `cp_*` ports. The FSM stays in `subsurf_sched`.

## Test plan
- levels=1, stage busy models each 20 cycles → starts seen 1→2→4 in order, each 3 cycles wide, no COPY, `done` once, `level_idx`=0.
- levels=2, copy_len=5, bank 2 preloaded 0xA0..0xA4 → bank 0 words 0–4 = 0xA0..0xA4 before the second subdiv start; copy lasts 6 cycles; `level_idx`=1 at `done`.
- levels=0 → `done` 2 cycles after `start`, `busy` stays 0, `stage_start` stays 0.
- WDOG_W=6, neighbor busy stuck high → `err`=1 after 63 WAIT cycles, `busy`=0, no `done`; next `start` clears `err`.
- `abort` during COPY at word 3 → IDLE next cycle, `cp_en0`=0, no `done`; a new job then runs normally.
- `start` pulsed mid-job and `rst` asserted mid-WAIT → no restart; all outputs reset asynchronously.
